// File: rtl/data_memory_responder.sv
// ============================================================================
// Module   : data_memory_responder
// Purpose  : MEM-stage data-memory slave. Accepts one load/store at a time,
//            places store bytes into their lanes, sign/zero-extends loads,
//            inserts WAIT_STATES extra cycles before a one-cycle response and
//            rejects misaligned, illegal-size, read+write or out-of-range
//            accesses with rsp_error.
// Ports    : clk, reset_n (async, active-low)
//            req_valid/req_ready handshake; req_addr (byte address),
//            req_wdata (right-aligned store data), req_read, req_write,
//            req_size (00 byte, 01 half, 10 word), req_sign
//            rsp_valid (1-cycle pulse), rsp_rdata, rsp_error; busy
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module data_memory_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_sign,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   output logic        busy
);

   localparam int         AW        = $clog2(DEPTH_WORDS);
   localparam logic [2:0] WAIT_INIT = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RESPOND = 2'd2
   } state_t;

   state_t      state, next_state;
   logic [2:0]  wait_cnt, wait_cnt_next;
   logic        ready_q;

   logic [31:0] lat_addr, lat_wdata;
   logic        lat_read, lat_write, lat_sign;
   logic [1:0]  lat_size;

   logic        accept, go_respond;
   logic [31:0] eff_addr, eff_wdata;
   logic        eff_read, eff_write, eff_sign;
   logic [1:0]  eff_size;

   logic        out_of_range, access_err, mem_we;
   logic [AW-1:0] idx;
   logic [31:0] rd_word, load_data, wdata_rep;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [3:0]  byte_en;

   logic [31:0] mem [DEPTH_WORDS];

   // ready is registered so it stays low during reset and rises on the first
   // edge after release; it mirrors "next state is IDLE".
   assign req_ready = ready_q;
   assign busy      = (state != ST_IDLE);
   assign accept    = req_valid & ready_q & (req_read | req_write);

   // With zero wait states the access happens on the accepting edge, so the
   // live request fields are used; otherwise the latched copy is used.
   assign eff_addr  = (state == ST_IDLE) ? req_addr  : lat_addr;
   assign eff_wdata = (state == ST_IDLE) ? req_wdata : lat_wdata;
   assign eff_read  = (state == ST_IDLE) ? req_read  : lat_read;
   assign eff_write = (state == ST_IDLE) ? req_write : lat_write;
   assign eff_size  = (state == ST_IDLE) ? req_size  : lat_size;
   assign eff_sign  = (state == ST_IDLE) ? req_sign  : lat_sign;

   assign out_of_range = ({2'b00, eff_addr[31:2]} >= 32'(DEPTH_WORDS));
   assign access_err   = (eff_size == 2'b11)
                       | ((eff_size == 2'b01) & eff_addr[0])
                       | ((eff_size == 2'b10) & (eff_addr[1:0] != 2'b00))
                       | (eff_read & eff_write)
                       | out_of_range;

   assign idx     = eff_addr[AW+1:2];
   assign rd_word = mem[idx];
   assign mem_we  = go_respond & eff_write & ~access_err;

   // Next-state logic
   always_comb begin
      next_state    = state;
      wait_cnt_next = wait_cnt;
      go_respond    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (WAIT_STATES == 0) begin
                  next_state = ST_RESPOND;
                  go_respond = 1'b1;
               end else begin
                  next_state    = ST_WAIT;
                  wait_cnt_next = WAIT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (wait_cnt == 3'd0) begin
               next_state = ST_RESPOND;
               go_respond = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt - 3'd1;
            end
         end
         ST_RESPOND: next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   // Load lane extraction and extension
   always_comb begin
      lane_byte = rd_word[7:0];
      case (eff_addr[1:0])
         2'd0:    lane_byte = rd_word[7:0];
         2'd1:    lane_byte = rd_word[15:8];
         2'd2:    lane_byte = rd_word[23:16];
         default: lane_byte = rd_word[31:24];
      endcase
      lane_half = eff_addr[1] ? rd_word[31:16] : rd_word[15:0];
      case (eff_size)
         2'b00:   load_data = eff_sign ? {{24{lane_byte[7]}}, lane_byte} : {24'd0, lane_byte};
         2'b01:   load_data = eff_sign ? {{16{lane_half[15]}}, lane_half} : {16'd0, lane_half};
         default: load_data = rd_word;
      endcase
   end

   // Store lane placement: replicate the data across lanes, then enable only
   // the addressed lanes.
   always_comb begin
      wdata_rep = eff_wdata;
      byte_en   = 4'b1111;
      case (eff_size)
         2'b00: begin
            wdata_rep = {4{eff_wdata[7:0]}};
            byte_en   = 4'b0001 << eff_addr[1:0];
         end
         2'b01: begin
            wdata_rep = {2{eff_wdata[15:0]}};
            byte_en   = eff_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata_rep = eff_wdata;
            byte_en   = 4'b1111;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         wait_cnt  <= 3'd0;
         ready_q   <= 1'b0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
         lat_read  <= 1'b0;
         lat_write <= 1'b0;
         lat_size  <= 2'b00;
         lat_sign  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_error <= 1'b0;
         rsp_rdata <= 32'd0;
      end else begin
         state    <= next_state;
         wait_cnt <= wait_cnt_next;
         ready_q  <= (next_state == ST_IDLE);
         if (accept) begin
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_read  <= req_read;
            lat_write <= req_write;
            lat_size  <= req_size;
            lat_sign  <= req_sign;
         end
         rsp_valid <= go_respond;
         rsp_error <= go_respond & access_err;
         rsp_rdata <= (go_respond && eff_read && !access_err) ? load_data : 32'd0;
      end
   end

   // Array contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
               mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_data_memory_responder.sv
// ============================================================================
// Module   : tb_data_memory_responder
// Purpose  : Directed self-checking bench for data_memory_responder. Three
//            instances with WAIT_STATES = 0, 1, 3 share request fields; each
//            has its own req_valid. Latency is counted in clock edges from
//            the accepting edge to the first cycle where rsp_valid is high.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_data_memory_responder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] addr, wdata;
   logic        rd, wr, sg;
   logic [1:0]  sz;
   logic        vld  [3];
   logic        rdy  [3];
   logic        rv   [3];
   logic        re   [3];
   logic        bsy  [3];
   logic [31:0] rdat [3];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // index 0: WAIT_STATES=0, index 1: WAIT_STATES=1, index 2: WAIT_STATES=3
   data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .reset_n(reset_n), .req_valid(vld[0]), .req_ready(rdy[0]),
      .req_addr(addr), .req_wdata(wdata), .req_read(rd), .req_write(wr),
      .req_size(sz), .req_sign(sg), .rsp_valid(rv[0]), .rsp_rdata(rdat[0]),
      .rsp_error(re[0]), .busy(bsy[0]));

   data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_ws1 (
      .clk(clk), .reset_n(reset_n), .req_valid(vld[1]), .req_ready(rdy[1]),
      .req_addr(addr), .req_wdata(wdata), .req_read(rd), .req_write(wr),
      .req_size(sz), .req_sign(sg), .rsp_valid(rv[1]), .rsp_rdata(rdat[1]),
      .rsp_error(re[1]), .busy(bsy[1]));

   data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .reset_n(reset_n), .req_valid(vld[2]), .req_ready(rdy[2]),
      .req_addr(addr), .req_wdata(wdata), .req_read(rd), .req_write(wr),
      .req_size(sz), .req_sign(sg), .rsp_valid(rv[2]), .rsp_rdata(rdat[2]),
      .rsp_error(re[2]), .busy(bsy[2]));

   // One transaction on instance d. Returns response data/error, latency in
   // edges (-1 on timeout) and hs=1 if ready stayed low / busy stayed high
   // until the response and rsp_valid was a single-cycle pulse.
   task automatic trans(input int d, input logic [31:0] a, input logic [31:0] w,
                        input logic r_i, input logic w_i, input logic [1:0] s_i,
                        input logic g_i, output logic [31:0] o_rdata,
                        output logic o_err, output int lat, output logic hs);
      int k;
      @(negedge clk);
      k = 0;
      while (!rdy[d] && k < 20) begin
         @(negedge clk);
         k++;
      end
      addr = a; wdata = w; rd = r_i; wr = w_i; sz = s_i; sg = g_i;
      vld[d] = 1'b1;
      @(negedge clk);
      vld[d] = 1'b0;
      hs = 1'b1; lat = -1; o_rdata = 'x; o_err = 1'bx;
      for (int i = 0; i < 20; i++) begin
         if (rdy[d] || !bsy[d]) hs = 1'b0;
         if (rv[d]) begin
            lat = i; o_rdata = rdat[d]; o_err = re[d];
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      if (rv[d] || bsy[d]) hs = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         tests++;
         if ({rdy[d], rv[d], re[d], bsy[d], rdat[d]} !== 36'd0) begin
            fails++;
            $display("FAIL reset_vals[%0d]: ready=%b valid=%b err=%b busy=%b rdata=%h, expected all 0",
                     d, rdy[d], rv[d], re[d], bsy[d], rdat[d]);
         end
      end
      reset_n = 1'b1;
      #1;
      tests++;
      if (rdy[1] !== 1'b0) begin
         fails++;
         $display("FAIL ready_before_edge: ready=%b expected 0", rdy[1]);
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         tests++;
         if (rdy[d] !== 1'b1 || bsy[d] !== 1'b0) begin
            fails++;
            $display("FAIL ready_after_release[%0d]: ready=%b busy=%b expected 1 0", d, rdy[d], bsy[d]);
         end
      end
   endtask

   task automatic test_word_rw();
      logic [31:0] r; logic e, ok; int lat;
      trans(1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 2'b10, 1'b0, r, e, lat, ok);
      tests++;
      if (lat !== 1 || e !== 1'b0 || r !== 32'h0 || ok !== 1'b1) begin
         fails++;
         $display("FAIL word_store: lat=%0d err=%b rdata=%h hs=%b, expected lat=1 err=0 rdata=00000000 hs=1", lat, e, r, ok);
      end
      trans(1, 32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b1, r, e, lat, ok);
      tests++;
      if (lat !== 1 || e !== 1'b0 || r !== 32'hDEADBEEF || ok !== 1'b1) begin
         fails++;
         $display("FAIL word_load: lat=%0d err=%b rdata=%h hs=%b, expected lat=1 err=0 rdata=deadbeef hs=1", lat, e, r, ok);
      end
   endtask

   // Runs a small load table on instance 1 with WAIT_STATES=1 latency.
   task automatic test_byte_lanes();
      logic [31:0] r; logic e, ok; int lat;
      logic [31:0] la [5]; logic [1:0] ls [5]; logic lg [5]; logic [31:0] lx [5];
      trans(1, 32'h13, 32'h12345680, 1'b0, 1'b1, 2'b00, 1'b0, r, e, lat, ok);
      tests++;
      if (lat !== 1 || e !== 1'b0 || r !== 32'h0 || ok !== 1'b1) begin
         fails++;
         $display("FAIL byte_store: lat=%0d err=%b rdata=%h hs=%b, expected lat=1 err=0 rdata=00000000 hs=1", lat, e, r, ok);
      end
      la = '{32'h13, 32'h13, 32'h10, 32'h11, 32'h12};
      ls = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
      lg = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      lx = '{32'hFFFFFF80, 32'h00000080, 32'h80ADBEEF, 32'hFFFFFFBE, 32'h000000AD};
      for (int i = 0; i < 5; i++) begin
         trans(1, la[i], 32'h0, 1'b1, 1'b0, ls[i], lg[i], r, e, lat, ok);
         tests++;
         if (lat !== 1 || e !== 1'b0 || r !== lx[i] || ok !== 1'b1) begin
            fails++;
            $display("FAIL byte_load[%0d]: lat=%0d err=%b rdata=%h hs=%b, expected lat=1 err=0 rdata=%h hs=1", i, lat, e, r, ok, lx[i]);
         end
      end
   endtask

   task automatic test_half();
      logic [31:0] r; logic e, ok; int lat;
      logic [31:0] la [4]; logic [1:0] ls [4]; logic lg [4]; logic [31:0] lx [4];
      trans(1, 32'h20, 32'h11112222, 1'b0, 1'b1, 2'b10, 1'b0, r, e, lat, ok);
      trans(1, 32'h22, 32'hABCD8001, 1'b0, 1'b1, 2'b01, 1'b0, r, e, lat, ok);
      tests++;
      if (lat !== 1 || e !== 1'b0 || r !== 32'h0) begin
         fails++;
         $display("FAIL half_store: lat=%0d err=%b rdata=%h, expected lat=1 err=0 rdata=00000000", lat, e, r);
      end
      la = '{32'h22, 32'h22, 32'h20, 32'h20};
      ls = '{2'b01, 2'b01, 2'b10, 2'b01};
      lg = '{1'b1, 1'b0, 1'b0, 1'b1};
      lx = '{32'hFFFF8001, 32'h00008001, 32'h80012222, 32'h00002222};
      for (int i = 0; i < 4; i++) begin
         trans(1, la[i], 32'h0, 1'b1, 1'b0, ls[i], lg[i], r, e, lat, ok);
         tests++;
         if (lat !== 1 || e !== 1'b0 || r !== lx[i]) begin
            fails++;
            $display("FAIL half_load[%0d]: lat=%0d err=%b rdata=%h, expected lat=1 err=0 rdata=%h", i, lat, e, r, lx[i]);
         end
      end
   endtask

   // Every rejected store below would land in word 0 if it were committed.
   task automatic test_errors();
      logic [31:0] r; logic e, ok, quiet; int lat;
      logic [31:0] ea [5]; logic er [5]; logic ew [5]; logic [1:0] es [5];
      trans(1, 32'h00, 32'hA5A55A5A, 1'b0, 1'b1, 2'b10, 1'b0, r, e, lat, ok);
      ea = '{32'h21, 32'h02, 32'h00, 32'h00, 32'h00001000};
      er = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      ew = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      es = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b10};
      for (int i = 0; i < 5; i++) begin
         trans(1, ea[i], 32'hFFFFFFFF, er[i], ew[i], es[i], 1'b1, r, e, lat, ok);
         tests++;
         if (lat !== 1 || e !== 1'b1 || r !== 32'h0 || ok !== 1'b1) begin
            fails++;
            $display("FAIL error_case[%0d]: lat=%0d err=%b rdata=%h hs=%b, expected lat=1 err=1 rdata=00000000 hs=1", i, lat, e, r, ok);
         end
      end
      trans(1, 32'h00, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, r, e, lat, ok);
      tests++;
      if (e !== 1'b0 || r !== 32'hA5A55A5A) begin
         fails++;
         $display("FAIL error_no_write: err=%b rdata=%h, expected err=0 rdata=a5a55a5a", e, r);
      end
      // valid without read or write is ignored
      @(negedge clk);
      addr = 32'h0; wdata = 32'hFFFFFFFF; rd = 1'b0; wr = 1'b0; sz = 2'b10;
      vld[1] = 1'b1;
      quiet = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (rv[1] || bsy[1] || !rdy[1]) quiet = 1'b0;
      end
      vld[1] = 1'b0;
      tests++;
      if (quiet !== 1'b1) begin
         fails++;
         $display("FAIL noop_request: activity=%b, expected none", !quiet);
      end
   endtask

   task automatic test_ws0();
      logic [31:0] r; logic e, ok; int lat;
      trans(0, 32'h40, 32'hCAFEF00D, 1'b0, 1'b1, 2'b10, 1'b0, r, e, lat, ok);
      tests++;
      if (lat !== 0 || e !== 1'b0 || r !== 32'h0 || ok !== 1'b1) begin
         fails++;
         $display("FAIL ws0_store: lat=%0d err=%b rdata=%h hs=%b, expected lat=0 err=0 rdata=00000000 hs=1", lat, e, r, ok);
      end
      trans(0, 32'h42, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, r, e, lat, ok);
      tests++;
      if (lat !== 0 || e !== 1'b0 || r !== 32'h0000CAFE || ok !== 1'b1) begin
         fails++;
         $display("FAIL ws0_load: lat=%0d err=%b rdata=%h hs=%b, expected lat=0 err=0 rdata=0000cafe hs=1", lat, e, r, ok);
      end
   endtask

   task automatic test_ws3_ignore();
      logic [31:0] r; logic e, ok; int lat, k;
      trans(2, 32'h54, 32'h00000011, 1'b0, 1'b1, 2'b10, 1'b0, r, e, lat, ok);
      trans(2, 32'h50, 32'h0BADF00D, 1'b0, 1'b1, 2'b10, 1'b0, r, e, lat, ok);
      tests++;
      if (lat !== 3 || e !== 1'b0 || r !== 32'h0 || ok !== 1'b1) begin
         fails++;
         $display("FAIL ws3_store: lat=%0d err=%b rdata=%h hs=%b, expected lat=3 err=0 rdata=00000000 hs=1", lat, e, r, ok);
      end
      // load 0x50, then scramble the fields with valid held while busy
      @(negedge clk);
      addr = 32'h50; wdata = 32'h0; rd = 1'b1; wr = 1'b0; sz = 2'b10; sg = 1'b0;
      vld[2] = 1'b1;
      @(negedge clk);
      addr = 32'h54; wdata = 32'hFFFFFFFF; rd = 1'b0; wr = 1'b1; sz = 2'b00; sg = 1'b1;
      lat = -1; r = 'x; e = 1'bx;
      for (k = 0; k < 20; k++) begin
         if (rv[2]) begin
            lat = k; r = rdat[2]; e = re[2];
            break;
         end
         @(negedge clk);
      end
      vld[2] = 1'b0;
      tests++;
      if (lat !== 3 || e !== 1'b0 || r !== 32'h0BADF00D) begin
         fails++;
         $display("FAIL ws3_held_fields: lat=%0d err=%b rdata=%h, expected lat=3 err=0 rdata=0badf00d", lat, e, r);
      end
      trans(2, 32'h54, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, r, e, lat, ok);
      tests++;
      if (r !== 32'h00000011 || e !== 1'b0) begin
         fails++;
         $display("FAIL ws3_no_stray_write: rdata=%h err=%b, expected 00000011 0", r, e);
      end
   endtask

   // With valid held, ready should rise every WAIT_STATES+2 cycles.
   task automatic test_back_to_back();
      int gap [3];
      int acc [3];
      int n;
      gap = '{2, 3, 5};
      for (int d = 0; d < 3; d++) begin
         @(negedge clk);
         addr = 32'h10; wdata = 32'h0; rd = 1'b1; wr = 1'b0; sz = 2'b10; sg = 1'b0;
         vld[d] = 1'b1;
         n = 0;
         acc = '{-1, -1, -1};
         for (int i = 0; i < 20; i++) begin
            if (rdy[d] && n < 3) begin
               acc[n] = i;
               n++;
            end
            @(negedge clk);
         end
         vld[d] = 1'b0;
         repeat (8) @(negedge clk);
         tests++;
         if (n !== 3 || (acc[1] - acc[0]) !== gap[d] || (acc[2] - acc[1]) !== gap[d]) begin
            fails++;
            $display("FAIL back_to_back[%0d]: accepts=%0d gaps=%0d,%0d, expected 3 gaps=%0d,%0d",
                     d, n, acc[1] - acc[0], acc[2] - acc[1], gap[d], gap[d]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r; logic e, ok, no_rsp; int lat, k;
      trans(2, 32'h30, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, r, e, lat, ok);
      @(negedge clk);
      k = 0;
      while (!rdy[2] && k < 20) begin
         @(negedge clk);
         k++;
      end
      addr = 32'h30; wdata = 32'h12345678; rd = 1'b0; wr = 1'b1; sz = 2'b10; sg = 1'b0;
      vld[2] = 1'b1;
      @(negedge clk);
      vld[2] = 1'b0;
      tests++;
      if (bsy[2] !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid_busy: busy=%b expected 1", bsy[2]);
      end
      reset_n = 1'b0;
      #1;
      tests++;
      if ({rdy[2], rv[2], re[2], bsy[2], rdat[2]} !== 36'd0) begin
         fails++;
         $display("FAIL reset_mid_vals: ready=%b valid=%b err=%b busy=%b rdata=%h, expected all 0",
                  rdy[2], rv[2], re[2], bsy[2], rdat[2]);
      end
      no_rsp = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (rv[2]) no_rsp = 1'b0;
      end
      reset_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (rv[2]) no_rsp = 1'b0;
      end
      tests++;
      if (no_rsp !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid_no_rsp: rsp_valid seen=%b expected 0", !no_rsp);
      end
      trans(2, 32'h30, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, r, e, lat, ok);
      tests++;
      if (lat !== 3 || e !== 1'b0 || r !== 32'h0) begin
         fails++;
         $display("FAIL reset_mid_no_write: lat=%0d err=%b rdata=%h, expected lat=3 err=0 rdata=00000000", lat, e, r);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      addr = 32'h0; wdata = 32'h0; rd = 1'b0; wr = 1'b0; sz = 2'b00; sg = 1'b0;
      for (int d = 0; d < 3; d++) vld[d] = 1'b0;
      test_reset();
      test_word_rw();
      test_byte_lanes();
      test_half();
      test_errors();
      test_ws0();
      test_ws3_ignore();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1);
   end

endmodule

`default_nettype wire
